alarm_ring_ctrl: RTL and testbench

Alarm ring sequencer for the digital clock. It compares the running time against the stored alarm time and, when they match and the alarm is enabled, drives a gated square-wave buzzer. The ring runs for a bounded duration and supports stop and a limited number of snoozes. It sits between the clock/alarm counters and the piezo output, and runs entirely on the system clock with single-cycle strobe inputs.

---
 rtl/alarm_ring_ctrl.sv | 155 +++++++++++++++
 tb/tb_alarm_ring_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alarm_ring_ctrl
// Desc     : Alarm time match, ring/snooze sequencing and gated buzzer tone.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_ring_ctrl #(
    parameter int CLK_HZ     = 50000000,
    parameter int TONE_HZ    = 1000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick_1hz,
    input  logic       i_alarm_en,
    input  logic [5:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_alarm_hour,
    input  logic [5:0] i_alarm_min,
    input  logic [5:0] i_alarm_sec,
    input  logic       i_stop,
    input  logic       i_snooze,
    output logic [1:0] o_state,
    output logic       o_ringing,
    output logic       o_buzz,
    output logic [1:0] o_snooze_left
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RING   = 2'd1;
    localparam logic [1:0] c_ST_SNOOZE = 2'd2;

    localparam int c_HALF_PER = CLK_HZ / (2 * TONE_HZ);
    localparam int c_DW = (c_HALF_PER > 1) ? $clog2(c_HALF_PER) : 1;
    localparam int c_RW = $clog2(RING_SEC);
    localparam int c_SW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
    localparam int c_UW = $clog2(MAX_SNOOZE + 1);

    logic [1:0]      r_state, w_state_next;
    logic            r_match_q, r_armed;
    logic            w_match, w_trigger;
    logic [c_RW-1:0] r_ring_cnt, w_ring_cnt_next;
    logic [c_SW-1:0] r_snz_cnt, w_snz_cnt_next;
    logic [c_UW-1:0] r_snz_used, w_snz_used_next;
    logic [c_DW-1:0] r_div;
    logic            r_tone, r_buzz;
    int              w_left;

    assign w_match = (i_hour == i_alarm_hour) && (i_min == i_alarm_min) &&
                     (i_sec == i_alarm_sec);
    // r_armed blocks the first cycle after reset so a match that was already
    // present across reset is not mistaken for a fresh edge.
    assign w_trigger = w_match && !r_match_q && r_armed && i_alarm_en &&
                       (r_state == c_ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_match_q  <= 1'b0;
            r_armed    <= 1'b0;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            r_snz_used <= '0;
        end else begin
            r_state    <= w_state_next;
            r_match_q  <= w_match;
            r_armed    <= 1'b1;
            r_ring_cnt <= w_ring_cnt_next;
            r_snz_cnt  <= w_snz_cnt_next;
            r_snz_used <= w_snz_used_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_ring_cnt_next = r_ring_cnt;
        w_snz_cnt_next  = r_snz_cnt;
        w_snz_used_next = r_snz_used;
        case (r_state)
            c_ST_IDLE: begin
                if (w_trigger)
                    w_state_next = c_ST_RING;
            end
            c_ST_RING: begin
                if (i_stop) begin
                    w_state_next = c_ST_IDLE;
                end else if (i_snooze && (r_snz_used < c_UW'(MAX_SNOOZE))) begin
                    w_state_next    = c_ST_SNOOZE;
                    w_snz_cnt_next  = '0;
                    w_snz_used_next = r_snz_used + 1'b1;
                end else if (i_tick_1hz) begin
                    if (r_ring_cnt == c_RW'(RING_SEC - 1))
                        w_state_next = c_ST_IDLE;
                    else
                        w_ring_cnt_next = r_ring_cnt + 1'b1;
                end
            end
            c_ST_SNOOZE: begin
                if (i_stop) begin
                    w_state_next = c_ST_IDLE;
                end else if (i_tick_1hz) begin
                    if (r_snz_cnt == c_SW'(SNOOZE_SEC - 1)) begin
                        w_state_next    = c_ST_RING;
                        w_ring_cnt_next = '0;
                    end else begin
                        w_snz_cnt_next = r_snz_cnt + 1'b1;
                    end
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
        if (!i_alarm_en)
            w_state_next = c_ST_IDLE;
        // Clearing on the way into IDLE makes the snooze display recover in
        // the same cycle as the state change.
        if (w_state_next == c_ST_IDLE) begin
            w_ring_cnt_next = '0;
            w_snz_cnt_next  = '0;
            w_snz_used_next = '0;
        end
    end

    always_comb begin
        o_state       = r_state;
        o_ringing     = (r_state == c_ST_RING);
        w_left        = MAX_SNOOZE - int'(r_snz_used);
        o_snooze_left = (w_left > 3) ? 2'd3 : 2'(w_left);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_tone <= 1'b0;
            r_buzz <= 1'b0;
        end else begin
            if (r_state != c_ST_RING) begin
                r_div  <= '0;
                r_tone <= 1'b0;
            end else if (r_div == c_DW'(c_HALF_PER - 1)) begin
                r_div  <= '0;
                r_tone <= ~r_tone;
            end else begin
                r_div <= r_div + 1'b1;
            end
            r_buzz <= r_tone && !r_ring_cnt[0] && (r_state == c_ST_RING);
        end
    end

    assign o_buzz = r_buzz;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_ring_ctrl
// Desc     : Scoreboard bench for alarm_ring_ctrl with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_ring_ctrl;

    localparam int CLK_HZ     = 1000;
    localparam int TONE_HZ    = 100;
    localparam int RING_SEC   = 4;
    localparam int SNOOZE_SEC = 3;
    localparam int MAX_SNOOZE = 2;
    localparam int HALF       = CLK_HZ / (2 * TONE_HZ);

    logic       clk, rst_n, i_tick_1hz, i_alarm_en, i_stop, i_snooze;
    logic [5:0] i_hour, i_min, i_sec, i_alarm_hour, i_alarm_min, i_alarm_sec;
    logic [1:0] o_state, o_snooze_left;
    logic       o_ringing, o_buzz;

    alarm_ring_ctrl #(
        .CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .RING_SEC(RING_SEC),
        .SNOOZE_SEC(SNOOZE_SEC), .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_tick_1hz(i_tick_1hz), .i_alarm_en(i_alarm_en),
        .i_hour(i_hour), .i_min(i_min), .i_sec(i_sec),
        .i_alarm_hour(i_alarm_hour), .i_alarm_min(i_alarm_min), .i_alarm_sec(i_alarm_sec),
        .i_stop(i_stop), .i_snooze(i_snooze),
        .o_state(o_state), .o_ringing(o_ringing), .o_buzz(o_buzz),
        .o_snooze_left(o_snooze_left)
    );

    typedef struct {
        int st;
        int ring;
        int buzz;
        int left;
    } sb_t;

    sb_t q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
        end
    endtask

    // Behavioural model: alarm modes 0=idle 1=ring 2=snooze, seconds counted
    // as plain integers, tone phase derived from clocks spent ringing.
    int m_mode, m_rsec, m_ssec, m_used, m_k, m_buzz;
    bit m_prev, m_live;
    always @(posedge clk) begin : p_model
        sb_t e;
        bit  match, trig;
        int  nm, buzz_n;
        if (!rst_n) begin
            m_mode = 0; m_rsec = 0; m_ssec = 0; m_used = 0; m_k = 0;
            m_buzz = 0; m_prev = 0; m_live = 0;
        end else begin
            buzz_n = (m_mode == 1 && ((m_k / HALF) % 2) == 1 && (m_rsec % 2) == 0) ? 1 : 0;
            match = (i_hour == i_alarm_hour) && (i_min == i_alarm_min) && (i_sec == i_alarm_sec);
            trig  = match && !m_prev && m_live && i_alarm_en && (m_mode == 0);
            nm = m_mode;
            if (!i_alarm_en) begin
                nm = 0;
            end else if (m_mode == 0) begin
                if (trig) nm = 1;
            end else if (m_mode == 1) begin
                if (i_stop) nm = 0;
                else if (i_snooze && m_used < MAX_SNOOZE) begin
                    nm = 2; m_used++; m_ssec = 0;
                end else if (i_tick_1hz) begin
                    if (m_rsec == RING_SEC - 1) nm = 0;
                    else m_rsec++;
                end
            end else begin
                if (i_stop) nm = 0;
                else if (i_tick_1hz) begin
                    if (m_ssec == SNOOZE_SEC - 1) begin nm = 1; m_rsec = 0; end
                    else m_ssec++;
                end
            end
            m_k = (nm == 1 && m_mode == 1) ? m_k + 1 : 0;
            if (nm == 0) begin m_rsec = 0; m_ssec = 0; m_used = 0; end
            m_mode = nm;
            m_buzz = buzz_n;
            m_prev = match;
            m_live = 1;
        end
        e.st   = m_mode;
        e.ring = (m_mode == 1) ? 1 : 0;
        e.buzz = m_buzz;
        e.left = (MAX_SNOOZE - m_used > 3) ? 3 : MAX_SNOOZE - m_used;
        q.push_back(e);
    end

    always @(negedge clk) begin : p_monitor
        sb_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("state", int'(o_state), e.st);
            chk("ringing", int'(o_ringing), e.ring);
            chk("buzz", int'(o_buzz), e.buzz);
            chk("snooze_left", int'(o_snooze_left), e.left);
        end
    end

    task automatic drive(input logic stp, input logic snz);
        @(posedge clk);
        #1;
        cyc++;
        i_tick_1hz = (cyc % 1000 == 0);
        i_stop     = stp;
        i_snooze   = snz;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    // Leaves the bench so that the next drive() carries a tick.
    task automatic to_tick();
        while ((cyc + 1) % 1000 != 0) drive(1'b0, 1'b0);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        i_hour = 6'(h); i_min = 6'(m); i_sec = 6'(s);
    endtask

    task automatic start_ring();
        set_time(7, 29, 59);
        drive(1'b0, 1'b0);
        set_time(7, 30, 0);
        drive(1'b0, 1'b0);
    endtask

    initial begin
        bit seen;
        int r;
        rst_n = 1'b0; i_tick_1hz = 1'b0; i_alarm_en = 1'b1; i_stop = 1'b0; i_snooze = 1'b0;
        i_alarm_hour = 6'd7; i_alarm_min = 6'd30; i_alarm_sec = 6'd0;
        set_time(7, 29, 59);
        idle(5);
        @(negedge clk); #1 rst_n = 1'b1;
        idle(20);

        // Basic ring through auto-stop, time held at the alarm second.
        start_ring();
        idle(4100);
        set_time(7, 31, 0);
        idle(10);

        // Stop early; the matching second must not re-ring.
        start_ring();
        idle(10);
        drive(1'b1, 1'b0);
        idle(200);
        set_time(7, 31, 0);
        idle(5);

        // Two snoozes, third ignored, then auto-stop.
        start_ring();
        idle(1500);
        drive(1'b0, 1'b1);
        idle(3100);
        drive(1'b0, 1'b1);
        idle(3100);
        drive(1'b0, 1'b1);
        idle(4100);
        set_time(7, 31, 0);
        idle(5);

        // Enable dropped during snooze.
        start_ring();
        idle(300);
        drive(1'b0, 1'b1);
        idle(500);
        i_alarm_en = 1'b0;
        idle(20);
        i_alarm_en = 1'b1;
        set_time(7, 31, 0);
        idle(5);

        // Tick coincident with stop, then tick at ring limit with snooze.
        start_ring();
        to_tick();
        drive(1'b1, 1'b0);
        idle(5);
        set_time(7, 31, 0);
        idle(5);
        start_ring();
        repeat (3) begin
            to_tick();
            drive(1'b0, 1'b0);
        end
        to_tick();
        drive(1'b0, 1'b1);
        idle(20);
        drive(1'b1, 1'b0);
        idle(5);
        set_time(7, 31, 0);
        idle(5);

        // Reset while buzzing; time still matches after release.
        start_ring();
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            drive(1'b0, 1'b0);
            if (o_buzz) seen = 1'b1;
        end
        chk("buzz_before_reset", int'(seen), 1);
        @(negedge clk); #1 rst_n = 1'b0;
        #1;
        chk("rst_state", int'(o_state), 0);
        chk("rst_ringing", int'(o_ringing), 0);
        chk("rst_buzz", int'(o_buzz), 0);
        chk("rst_snooze_left", int'(o_snooze_left), 2);
        idle(5);
        @(negedge clk); #1 rst_n = 1'b1;
        idle(50);
        chk("no_ring_after_reset", int'(o_state), 0);
        set_time(7, 31, 0);
        idle(5);

        // Randomized time matches, buttons and enable changes.
        for (int i = 0; i < 20000; i++) begin
            r = int'($urandom_range(0, 9999));
            if (r < 25) begin
                if ($urandom_range(0, 1) == 0) set_time(7, 30, 0);
                else set_time(7, 30, int'($urandom_range(1, 59)));
            end
            if ($urandom_range(0, 2999) == 0) i_alarm_en = ~i_alarm_en;
            drive(r >= 25 && r < 32, r >= 32 && r < 45);
        end
        i_alarm_en = 1'b1;
        idle(10);

        @(negedge clk); #1;
        chk("queue_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
